// File: rtl/fpu_pkg.sv
// Shared FPU datapath types and widths.
// Holds default widths and the normalizer stage payload.
package fpu_pkg;

  localparam int MW = 24;
  localparam int EW = 8;
  localparam int TW = 4;
  localparam int CW = $clog2(MW + 1);

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
    logic [TW-1:0] tag;
    logic [CW-1:0] lzc;
    logic [EW-1:0] max_shift;
  } stage_t;

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter: 8-bit leaves plus a merge.
// Ports: mant (W bits) in, cnt (0..W) out.
module lzc_tree #(
  parameter int W  = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  mant,
  output logic [CW-1:0] cnt
);

  localparam int NL = (W + 7) / 8;
  localparam int PW = NL * 8;

  function automatic logic [3:0] lzc8(
    input logic [7:0] b
  );
    logic [3:0] r;
    r = 4'd8;
    for (int i = 0; i < 8; i++)
      if (b[i]) r = 4'(7 - i);
    return r;
  endfunction

  // zero padding sits below the lsb so it
  // never shortens a nonzero count
  logic [PW-1:0] pad;
  assign pad = PW'(mant) << (PW - W);

  logic [3:0] leaf [NL];

  for (genvar g = 0; g < NL; g++) begin : g_leaf
    assign leaf[g] = lzc8(pad[PW-1-8*g -: 8]);
  end

  logic found;

  always_comb begin
    cnt   = CW'(W);
    found = 1'b0;
    for (int g = 0; g < NL; g++) begin
      if (!found && leaf[g] != 4'd8) begin
        cnt   = CW'(8 * g + int'(leaf[g]));
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage post-normalizer: lzc, left shift, exponent adjust.
// in_* / out_* valid-ready beats; sign and tag pass through.
module fp_norm_pipe
  import fpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [MW-1:0] in_mant,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exp,
  output logic [MW-1:0] out_mant,
  output logic [TW-1:0] out_tag,
  output logic          out_zero,
  output logic          out_tiny
);

  logic   s1_valid;
  logic   s2_valid;
  stage_t s1_q;
  stage_t s1_d;
  logic   s2_load;

  logic [CW-1:0] lzc_in;

  lzc_tree #(
    .W  (MW),
    .CW (CW)
  ) u_lzc (
    .mant (in_mant),
    .cnt  (lzc_in)
  );

  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;
  assign out_valid = s2_valid;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.exp  = in_exp;
    s1_d.mant = in_mant;
    s1_d.tag  = in_tag;
    s1_d.lzc  = lzc_in;
    s1_d.max_shift = (in_exp == '0)
      ? '0 : in_exp - EW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic [EW:0]   lzc_x;
  logic [EW:0]   max_x;
  logic [CW-1:0] sh;
  logic          mz;
  logic [EW-1:0] n_exp;
  logic [MW-1:0] n_mant;
  logic          n_zero;
  logic          n_tiny;

  always_comb begin
    lzc_x  = {{(EW+1-CW){1'b0}}, s1_q.lzc};
    max_x  = {1'b0, s1_q.max_shift};
    mz     = (s1_q.mant == '0);
    sh     = '0;
    n_exp  = '0;
    n_mant = '0;
    n_zero = 1'b0;
    n_tiny = 1'b0;
    unique case (1'b1)
      mz: n_zero = 1'b1;
      (!mz && lzc_x <= max_x): begin
        sh     = s1_q.lzc;
        n_exp  = s1_q.exp - EW'(s1_q.lzc);
        n_mant = s1_q.mant << sh;
      end
      // here max_shift < lzc <= MW, so it fits in CW
      (!mz && lzc_x > max_x): begin
        sh     = s1_q.max_shift[CW-1:0];
        n_tiny = 1'b1;
        n_mant = s1_q.mant << sh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sign <= 1'b0;
      out_exp  <= '0;
      out_mant <= '0;
      out_tag  <= '0;
      out_zero <= 1'b0;
      out_tiny <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sign <= s1_q.sign;
        out_exp  <= n_exp;
        out_mant <= n_mant;
        out_tag  <= s1_q.tag;
        out_zero <= n_zero;
        out_tiny <= n_tiny;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Directed bench for fp_norm_pipe: vector table plus
// backpressure and mid-flight reset sequences.
module tb_fp_norm_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_mant;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic [3:0]  out_tag;
  logic        out_zero;
  logic        out_tiny;

  fp_norm_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .out_tiny  (out_tiny)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic [3:0]  t;
    logic [7:0]  xe;
    logic [23:0] xm;
    logic        xz;
    logic        xt;
  } vec_t;

  vec_t vt[11];

  function automatic logic [39:0] ov();
    return {out_valid, out_sign, out_exp, out_mant,
            out_tag, out_zero, out_tiny};
  endfunction

  function automatic logic [39:0] xv(
    input logic v, input logic s, input logic [7:0] e,
    input logic [23:0] m, input logic [3:0] t,
    input logic z, input logic ti
  );
    return {v, s, e, m, t, z, ti};
  endfunction

  task automatic cmp(
    input string nm,
    input logic [39:0] got,
    input logic [39:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  logic [3:0] got_q[$];
  int acc;

  initial begin
    vt[0]  = '{0, 8'd100, 24'h000001, 4'd1,
               8'd77, 24'h800000, 0, 0};
    vt[1]  = '{0, 8'd5,   24'h001000, 4'd2,
               8'd0,  24'h010000, 0, 1};
    vt[2]  = '{1, 8'h80,  24'h000000, 4'd3,
               8'd0,  24'h000000, 1, 0};
    vt[3]  = '{0, 8'h00,  24'h800000, 4'd4,
               8'd0,  24'h800000, 0, 0};
    vt[4]  = '{0, 8'h7F,  24'hC00000, 4'd5,
               8'h7F, 24'hC00000, 0, 0};
    vt[5]  = '{1, 8'd1,   24'h000010, 4'd6,
               8'd0,  24'h000010, 0, 1};
    vt[6]  = '{0, 8'h20,  24'h000100, 4'd7,
               8'h11, 24'h800000, 0, 0};
    vt[7]  = '{0, 8'd24,  24'h000001, 4'd8,
               8'd1,  24'h800000, 0, 0};
    vt[8]  = '{1, 8'd23,  24'h000001, 4'd9,
               8'd0,  24'h400000, 0, 1};
    vt[9]  = '{0, 8'hFF,  24'h3FFFFF, 4'd10,
               8'hFD, 24'hFFFFFC, 0, 0};
    vt[10] = '{0, 8'h00,  24'h400000, 4'd11,
               8'd0,  24'h400000, 0, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #1;
    cmp("rst_out", ov(), 40'h0);
    cmp("rst_rdy", 40'(in_ready), 40'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single-beat vectors, fixed two-edge latency
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_sign   = vt[i].s;
      in_exp    = vt[i].e;
      in_mant   = vt[i].m;
      in_tag    = vt[i].t;
      #1;
      cmp($sformatf("v%0d_rdy", i), 40'(in_ready), 40'h1);
      @(negedge clk);
      in_valid = 1'b0;
      cmp($sformatf("v%0d_lat1", i), 40'(out_valid), 40'h0);
      @(negedge clk);
      cmp($sformatf("v%0d", i), ov(),
          xv(1'b1, vt[i].s, vt[i].xe, vt[i].xm,
             vt[i].t, vt[i].xz, vt[i].xt));
    end

    // backpressure: 5 beats, downstream stalled early
    @(negedge clk);
    acc = 0;
    for (int c = 0; c < 40 && got_q.size() < 5; c++) begin
      @(negedge clk);
      out_ready = (c >= 6);
      in_valid  = (acc < 5);
      in_sign   = 1'b0;
      in_tag    = acc[3:0];
      in_exp    = 8'(10 + acc);
      in_mant   = 24'h800000;
      #1;
      if (c == 2)
        cmp("bp_inrdy", 40'(in_ready), 40'h0);
      if (c == 2 || c == 5)
        cmp($sformatf("bp_hold%0d", c), ov(),
            xv(1'b1, 1'b0, 8'd10, 24'h800000,
               4'd0, 1'b0, 1'b0));
      if (out_valid && out_ready)
        got_q.push_back(out_tag);
      if (in_valid && in_ready)
        acc++;
    end
    in_valid = 1'b0;
    cmp("bp_count", 40'(got_q.size()), 40'd5);
    for (int k = 0; k < got_q.size(); k++)
      cmp($sformatf("bp_tag%0d", k), 40'(got_q[k]), 40'(k));

    // reset while both stages hold beats
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_exp    = 8'd50;
    in_mant   = 24'h000100;
    in_tag    = 4'd12;
    @(negedge clk);
    in_tag    = 4'd13;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    cmp("full_inrdy", 40'(in_ready), 40'h0);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("mid_rst_out", ov(), 40'h0);
    cmp("mid_rst_rdy", 40'(in_ready), 40'h1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sign   = 1'b1;
    in_exp    = 8'd100;
    in_mant   = 24'h000001;
    in_tag    = 4'd14;
    @(negedge clk);
    in_valid = 1'b0;
    cmp("post_rst_lat1", ov(), 40'h0);
    @(negedge clk);
    cmp("post_rst_beat", ov(),
        xv(1'b1, 1'b1, 8'd77, 24'h800000,
           4'd14, 1'b0, 1'b0));
    @(negedge clk);
    cmp("post_rst_drain", 40'(out_valid), 40'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
